pio_access_ctrl: RTL and testbench

- Host-side front end of the PIO path. It buffers host register-access requests in a 2-entry FIFO and drives the ATA address and data lines.
- It issues go/we strobes to the PIO timing controller and waits for its done. It captures read data on dstrb and returns one response per request.
- A watchdog aborts cycles whose done never arrives, for example when IORDY is stuck low.

---
 rtl/pio_access_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pio_access_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pio_access_ctrl                                               |
// | Purpose  : Host-side front end of the ATA PIO path. Queues host register |
// |            accesses in a 2-entry FIFO, drives DA/CS/DD towards the bus,  |
// |            strobes the PIO timing controller and returns one response    |
// |            per request. A watchdog aborts cycles whose done never comes. |
// | Ports    : clk, rst (async, active high)                                 |
// |            host  : req/req_rdy/req_we/req_adr/req_dat,                   |
// |                    resp_vld/resp_err/resp_dat                            |
// |            timing: pio_go/pio_we/pio_abort out,                          |
// |                    pio_done/pio_dstrb/pio_oe in                          |
// |            ATA   : DA, CS0n, CS1n, DDo, DDoe out; DDi in                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pio_access_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int TOUT    = 4096,
    parameter int TOWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              req_rdy,
    input  logic              req_we,
    input  logic [3:0]        req_adr,
    input  logic [DWIDTH-1:0] req_dat,
    output logic              resp_vld,
    output logic              resp_err,
    output logic [DWIDTH-1:0] resp_dat,
    output logic              pio_go,
    output logic              pio_we,
    output logic              pio_abort,
    input  logic              pio_done,
    input  logic              pio_dstrb,
    input  logic              pio_oe,
    output logic [2:0]        DA,
    output logic              CS0n,
    output logic              CS1n,
    output logic [DWIDTH-1:0] DDo,
    output logic              DDoe,
    input  logic [DWIDTH-1:0] DDi
);

    // FIFO entry layout: {we, adr[3:0], dat}
    localparam int c_EW = 1 + 4 + DWIDTH;

    // Watchdog fires on the edge that completes the TOUT-th WAIT cycle.
    localparam bit               c_WD_EN   = (TOUT != 0);
    localparam logic [TOWIDTH-1:0] c_WD_LAST = TOWIDTH'(TOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_q;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [c_EW-1:0] fifo_mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_d;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;
    logic            w_head_we;
    logic [3:0]      w_head_adr;
    logic [DWIDTH-1:0] w_head_dat;

    assign w_full  = cnt_q[1];
    assign w_empty = (cnt_q == 2'd0);
    // Ready depends only on the stored count, so a same-cycle pop on a full
    // FIFO does not open the door for a push in that cycle.
    assign req_rdy = !w_full;
    assign w_push  = req && !w_full;
    assign w_pop   = (state_q == ST_IDLE) && !w_empty;

    assign w_head     = fifo_mem_q[rd_ptr_q];
    assign w_head_we  = w_head[c_EW-1];
    assign w_head_adr = w_head[DWIDTH+3:DWIDTH];
    assign w_head_dat = w_head[DWIDTH-1:0];

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (w_push) wr_ptr_q <= ~wr_ptr_q;
            if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= {req_we, req_adr, req_dat};
    end

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    logic [TOWIDTH-1:0] wd_q;
    logic [DWIDTH-1:0]  rdat_q;
    logic               resp_vld_q;
    logic               resp_err_q;
    logic [DWIDTH-1:0]  resp_dat_q;
    logic               go_q;
    logic               we_q;
    logic               abort_q;
    logic [2:0]         da_q;
    logic               cs0n_q;
    logic               cs1n_q;
    logic [DWIDTH-1:0]  ddo_q;
    logic               ddoe_q;

    logic               w_wd_hit;
    logic [DWIDTH-1:0]  w_rd_last;

    assign w_wd_hit  = c_WD_EN && (wd_q == c_WD_LAST);
    // A strobe coinciding with done still supplies the returned read data.
    assign w_rd_last = pio_dstrb ? DDi : rdat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wd_q       <= '0;
            rdat_q     <= '0;
            resp_vld_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_dat_q <= '0;
            go_q       <= 1'b0;
            we_q       <= 1'b0;
            abort_q    <= 1'b0;
            da_q       <= 3'd0;
            cs0n_q     <= 1'b1;
            cs1n_q     <= 1'b1;
            ddo_q      <= '0;
            ddoe_q     <= 1'b0;
        end else begin
            resp_vld_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ddoe_q <= 1'b0;
                    if (w_pop) begin
                        da_q    <= w_head_adr[2:0];
                        cs0n_q  <= w_head_adr[3];
                        cs1n_q  <= ~w_head_adr[3];
                        we_q    <= w_head_we;
                        ddo_q   <= w_head_dat;
                        rdat_q  <= '0;
                        go_q    <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    go_q    <= 1'b0;
                    wd_q    <= '0;
                    ddoe_q  <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pio_dstrb) rdat_q <= DDi;
                    if (pio_done) begin
                        // done has priority over a watchdog hit in the same cycle
                        resp_vld_q <= 1'b1;
                        resp_err_q <= 1'b0;
                        resp_dat_q <= we_q ? '0 : w_rd_last;
                        cs0n_q     <= 1'b1;
                        cs1n_q     <= 1'b1;
                        ddoe_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (w_wd_hit) begin
                        abort_q    <= 1'b1;
                        resp_vld_q <= 1'b1;
                        resp_err_q <= 1'b1;
                        resp_dat_q <= '1;
                        cs0n_q     <= 1'b1;
                        cs1n_q     <= 1'b1;
                        ddoe_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        ddoe_q <= pio_oe & we_q;
                        // saturate rather than wrap when the watchdog is off
                        if (wd_q != '1) wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_vld  = resp_vld_q;
    assign resp_err  = resp_err_q;
    assign resp_dat  = resp_dat_q;
    assign pio_go    = go_q;
    assign pio_we    = we_q;
    assign pio_abort = abort_q;
    assign DA        = da_q;
    assign CS0n      = cs0n_q;
    assign CS1n      = cs1n_q;
    assign DDo       = ddo_q;
    assign DDoe      = ddoe_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pio_access_ctrl                                            |
// | Purpose  : Randomized self-checking bench for pio_access_ctrl. A host    |
// |            driver, a timing-controller responder and a transaction-level |
// |            reference model share one negedge process.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pio_access_ctrl;

    localparam int DW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          req_rdy;
    logic          req_we = 1'b0;
    logic [3:0]    req_adr = 4'd0;
    logic [DW-1:0] req_dat = '0;
    logic          resp_vld;
    logic          resp_err;
    logic [DW-1:0] resp_dat;
    logic          pio_go;
    logic          pio_we;
    logic          pio_abort;
    logic          pio_done = 1'b0;
    logic          pio_dstrb = 1'b0;
    logic          pio_oe = 1'b0;
    logic [2:0]    DA;
    logic          CS0n;
    logic          CS1n;
    logic [DW-1:0] DDo;
    logic          DDoe;
    logic [DW-1:0] DDi = '0;

    pio_access_ctrl #(
        .DWIDTH (DW),
        .TOUT   (TO),
        .TOWIDTH(16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_rdy  (req_rdy),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_dat  (req_dat),
        .resp_vld (resp_vld),
        .resp_err (resp_err),
        .resp_dat (resp_dat),
        .pio_go   (pio_go),
        .pio_we   (pio_we),
        .pio_abort(pio_abort),
        .pio_done (pio_done),
        .pio_dstrb(pio_dstrb),
        .pio_oe   (pio_oe),
        .DA       (DA),
        .CS0n     (CS0n),
        .CS1n     (CS1n),
        .DDo      (DDo),
        .DDoe     (DDoe),
        .DDi      (DDi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // k = cycle (counted from the cycle go is seen) in which done is driven; 0 = never
    typedef struct {
        bit          we;
        logic [3:0]  adr;
        logic [15:0] dat;
        int          k;
        bit          fix;
        logic [15:0] fixv;
    } req_t;

    typedef struct {
        req_t r;
        int   acc;
    } pend_t;

    req_t  host_q[$];
    pend_t fifo_m[$];

    int          ncyc = 0;
    int          resp_neg_last = -100;
    int          n0 = 0;
    int          term_neg = 0;
    int          resp_cnt = 0;
    bit          active = 1'b0;
    bit          await_resp = 1'b0;
    bit          exp_err = 1'b0;
    logic [15:0] exp_dat = '0;
    logic [15:0] rd_exp = '0;
    bit          ddoe_exp = 1'b0;
    bit          prev_go = 1'b0;
    bit          burst = 1'b0;
    req_t        cur;

    always @(negedge clk) begin
        pend_t       p;
        req_t        nr;
        int          j;
        int          exp_go;
        bit          dn;
        bit          tmo;
        bit          stb;
        bit          oe_v;
        bit          exp_now;
        logic [15:0] ddi_v;

        ncyc++;
        if (rst) begin
            fifo_m.delete();
            host_q.delete();
            active = 1'b0;
            await_resp = 1'b0;
            ddoe_exp = 1'b0;
            prev_go = 1'b0;
            resp_neg_last = -100;
            req = 1'b0;
            pio_done = 1'b0;
            pio_dstrb = 1'b0;
            pio_oe = 1'b0;
        end else begin
            // ---- responses ----
            exp_now = await_resp && (ncyc == term_neg);
            check_val("resp_vld", resp_vld, exp_now);
            check_val("pio_abort", pio_abort, exp_now && exp_err);
            if (exp_now) begin
                check_val("resp_err", resp_err, exp_err);
                check_val("resp_dat", resp_dat, exp_dat);
                check_val("cs_release", {CS0n, CS1n}, 2'b11);
                await_resp = 1'b0;
                resp_cnt++;
                resp_neg_last = ncyc;
            end
            check_val("DDoe", DDoe, ddoe_exp);
            if (!CS0n && !CS1n) check_val("cs_excl", 1, 0);

            // ---- go / issued access ----
            if (pio_go) begin
                check_val("go_width", prev_go, 0);
                if (!prev_go) begin
                    if (active || await_resp || fifo_m.size() == 0) begin
                        check_val("go_unexpected", 1, 0);
                    end else begin
                        p = fifo_m.pop_front();
                        exp_go = p.acc + 2;
                        if (resp_neg_last + 1 > exp_go) exp_go = resp_neg_last + 1;
                        check_val("go_time", ncyc, exp_go);
                        check_val("DA", DA, p.r.adr[2:0]);
                        check_val("CS0n", CS0n, p.r.adr[3]);
                        check_val("CS1n", CS1n, !p.r.adr[3]);
                        check_val("pio_we", pio_we, p.r.we);
                        check_val("DDo", DDo, p.r.dat);
                        cur = p.r;
                        active = 1'b1;
                        n0 = ncyc;
                        rd_exp = '0;
                    end
                end
            end
            prev_go = pio_go;
            if (active) check_val("DDo_hold", DDo, cur.dat);
            check_val("req_rdy", req_rdy, fifo_m.size() < 2);

            // ---- host driver ----
            if (host_q.size() != 0 && (burst || $urandom_range(3) != 0)) begin
                nr = host_q[0];
                req = 1'b1;
                req_we = nr.we;
                req_adr = nr.adr;
                req_dat = nr.dat;
                if (fifo_m.size() < 2) begin
                    void'(host_q.pop_front());
                    p.r = nr;
                    p.acc = ncyc;
                    fifo_m.push_back(p);
                end
            end else begin
                req = 1'b0;
                req_we = 1'($urandom);
                req_adr = 4'($urandom);
                req_dat = 16'($urandom);
            end

            // ---- timing-controller responder ----
            if (active && ncyc > n0) begin
                j = ncyc - n0;
                dn = (cur.k != 0) && (j == cur.k);
                tmo = !dn && (j == TO);
                stb = (j == 1) || ($urandom_range(2) == 0);
                ddi_v = cur.fix ? cur.fixv : 16'($urandom);
                oe_v = 1'($urandom);
                pio_done = dn;
                pio_dstrb = stb;
                DDi = ddi_v;
                pio_oe = oe_v;
                if (stb) rd_exp = ddi_v;
                if (dn || tmo) begin
                    active = 1'b0;
                    await_resp = 1'b1;
                    term_neg = ncyc + 1;
                    exp_err = tmo;
                    exp_dat = tmo ? 16'hFFFF : (cur.we ? 16'h0000 : rd_exp);
                    ddoe_exp = 1'b0;
                end else begin
                    ddoe_exp = oe_v & cur.we;
                end
            end else begin
                pio_done = 1'b0;
                pio_dstrb = 1'b0;
                pio_oe = 1'($urandom);
                DDi = 16'($urandom);
                ddoe_exp = 1'b0;
            end
        end
    end

    task automatic push_req(input bit we, input logic [3:0] adr, input logic [15:0] dat,
                            input int k, input bit fix, input logic [15:0] fixv);
        req_t r;
        r.we = we;
        r.adr = adr;
        r.dat = dat;
        r.k = k;
        r.fix = fix;
        r.fixv = fixv;
        host_q.push_back(r);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((host_q.size() != 0 || fifo_m.size() != 0 || active || await_resp) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val(tag, n < budget, 1);
    endtask

    task automatic check_reset_vals();
        check_val("rst_CS0n", CS0n, 1);
        check_val("rst_CS1n", CS1n, 1);
        check_val("rst_DA", DA, 0);
        check_val("rst_DDo", DDo, 0);
        check_val("rst_DDoe", DDoe, 0);
        check_val("rst_go", pio_go, 0);
        check_val("rst_we", pio_we, 0);
        check_val("rst_abort", pio_abort, 0);
        check_val("rst_resp_vld", resp_vld, 0);
        check_val("rst_resp_err", resp_err, 0);
        check_val("rst_resp_dat", resp_dat, 0);
        check_val("rst_req_rdy", req_rdy, 1);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(negedge clk);
        #1;
        check_reset_vals();
        #1 rst = 1'b0;

        // directed write: CS0, DA=7, done after 40 cycles
        base = resp_cnt;
        push_req(1'b1, 4'h7, 16'h00EC, 40, 1'b0, 16'h0);
        wait_done("budget_write", 300);
        check_val("cnt_write", resp_cnt - base, 1);

        // directed read: CS1, DA=6, strobed data 1234
        base = resp_cnt;
        push_req(1'b0, 4'hE, 16'hBEEF, 25, 1'b1, 16'h1234);
        wait_done("budget_read", 300);
        check_val("cnt_read", resp_cnt - base, 1);

        // three back-to-back writes
        base = resp_cnt;
        burst = 1'b1;
        for (int i = 0; i < 3; i++)
            push_req(1'b1, 4'($urandom), 16'($urandom), 10 + 3 * i, 1'b0, 16'h0);
        wait_done("budget_burst", 500);
        burst = 1'b0;
        check_val("cnt_burst", resp_cnt - base, 3);

        // timeout followed by a normal queued read
        base = resp_cnt;
        burst = 1'b1;
        push_req(1'b1, 4'h2, 16'h5A5A, 0, 1'b0, 16'h0);
        push_req(1'b0, 4'h9, 16'h0000, 12, 1'b1, 16'hC3C3);
        wait_done("budget_tmo", 500);
        burst = 1'b0;
        check_val("cnt_tmo", resp_cnt - base, 2);

        // done on the same cycle the watchdog would fire
        base = resp_cnt;
        push_req(1'b0, 4'h1, 16'h0, TO, 1'b1, 16'h7E57);
        wait_done("budget_tie", 300);
        check_val("cnt_tie", resp_cnt - base, 1);

        // randomized accesses, some never done
        base = resp_cnt;
        for (int i = 0; i < 16; i++)
            push_req(1'($urandom), 4'($urandom), 16'($urandom),
                     ($urandom_range(7) == 0) ? 0 : int'($urandom_range(80, 1)),
                     1'b0, 16'h0);
        wait_done("budget_rand", 3000);
        check_val("cnt_rand", resp_cnt - base, 16);

        // reset while in WAIT with one request queued
        base = resp_cnt;
        burst = 1'b1;
        push_req(1'b1, 4'h3, 16'hAAAA, 0, 1'b0, 16'h0);
        push_req(1'b0, 4'h9, 16'h0, 5, 1'b0, 16'h0);
        n = 0;
        while (!(active && fifo_m.size() == 1 && host_q.size() == 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("rst_setup", n < 200, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        burst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_val("rst_no_resp", resp_cnt - base, 0);

        // a fresh request after reset completes normally
        base = resp_cnt;
        push_req(1'b0, 4'hC, 16'h0, 7, 1'b1, 16'h4321);
        wait_done("budget_post_rst", 300);
        check_val("cnt_post_rst", resp_cnt - base, 1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
